// File: rtl/core_pkg.sv
// Shared opcode constants, FSM state encoding and ALU operation select for param_core.
package core_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLdi   = 4'h1;
  localparam logic [3:0] OpMovr  = 4'h2;
  localparam logic [3:0] OpMova  = 4'h3;
  localparam logic [3:0] OpAdd   = 4'h4;
  localparam logic [3:0] OpSub   = 4'h5;
  localparam logic [3:0] OpMul   = 4'h6;
  localparam logic [3:0] OpInc   = 4'h7;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpJnz   = 4'hA;
  localparam logic [3:0] OpJmp   = 4'hB;
  localparam logic [3:0] OpLdid  = 4'hC;
  localparam logic [3:0] OpEnd   = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StExec,
    StMem,
    StMemWait,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    AluAdd,
    AluSub,
    AluMul
  } alu_op_e;

endpackage

// File: rtl/core_alu.sv
// Accumulator arithmetic (wrapping add/sub/mul) and zero detect of the next AC value.
module core_alu
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_zin,
  output logic [DATA_W-1:0] o_y,
  output logic              o_zero
);

  // Same-width operands and result: every operation wraps modulo 2^DATA_W.
  always_comb begin
    o_y = i_a + i_b;
    case (i_op)
      AluSub:  o_y = i_a - i_b;
      AluMul:  o_y = i_a * i_b;
      default: ;
    endcase
  end

  assign o_zero = (i_zin == '0);

endmodule

// File: rtl/param_core.sv
// Accumulator core: 3-cycle fetch/latch/exec sequencer, register file and shared-DRAM port.
module param_core
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] core_id,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_rdata,
  output logic              dram_req,
  input  logic              dram_gnt,
  output logic              dram_wren,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ac_out,
  output logic              z,
  output logic              busy,
  output logic              end_process
);

  localparam int unsigned RegW = $clog2(NREG);
  localparam int unsigned ImmW = DATA_W - 4;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ac;
  logic [DATA_W-1:0] r_ir;
  logic              r_z;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_dram_req;
  logic              r_dram_wren;
  logic [ADDR_W-1:0] r_dram_addr;
  logic [DATA_W-1:0] r_dram_wdata;
  logic              r_busy;
  logic              r_end;

  logic [3:0]        w_op;
  logic [ImmW-1:0]   w_imm;
  logic [DATA_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_target;
  logic [RegW-1:0]   w_n;
  logic [DATA_W-1:0] w_rn;
  alu_op_e           w_alu_op;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_ac_we;
  logic [DATA_W-1:0] w_ac_new;
  logic              w_ac_zero;
  logic              w_unused;

  assign w_op      = r_ir[DATA_W-1 -: 4];
  assign w_imm     = r_ir[ImmW-1:0];
  assign w_imm_ext = {4'b0000, w_imm};
  assign w_target  = w_imm_ext[ADDR_W-1:0];
  assign w_n       = w_imm[RegW-1:0];
  assign w_rn      = r_regs[w_n];
  // Upper immediate bits beyond the PC width are dropped on jumps.
  assign w_unused  = ^w_imm_ext;

  // Select ALU operation from the latched opcode.
  always_comb begin
    w_alu_op = AluAdd;
    if (w_op == OpSub) w_alu_op = AluSub;
    if (w_op == OpMul) w_alu_op = AluMul;
  end

  core_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a    (r_ac),
    .i_b    (w_rn),
    .i_op   (w_alu_op),
    .i_zin  (w_ac_new),
    .o_y    (w_alu_y),
    .o_zero (w_ac_zero)
  );

  // Decide whether AC is written this cycle and with what; z follows every AC write.
  always_comb begin
    w_ac_we  = 1'b0;
    w_ac_new = w_alu_y;
    if (r_state == StMemWait) begin
      w_ac_we  = 1'b1;
      w_ac_new = dram_rdata;
    end else if (r_state == StExec) begin
      case (w_op)
        OpLdi: begin
          w_ac_we  = 1'b1;
          w_ac_new = w_imm_ext;
        end
        OpMovr: begin
          w_ac_we  = 1'b1;
          w_ac_new = w_rn;
        end
        OpAdd, OpSub, OpMul: w_ac_we = 1'b1;
        OpLdid: begin
          w_ac_we  = 1'b1;
          w_ac_new = core_id;
        end
        default: ;
      endcase
    end
  end

  // Sequencer, register file and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pc         <= '0;
      r_ac         <= '0;
      r_ir         <= '0;
      r_z          <= 1'b1;
      r_dram_req   <= 1'b0;
      r_dram_wren  <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_wdata <= '0;
      r_busy       <= 1'b0;
      r_end        <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StFetch;
            r_busy  <= 1'b1;
          end
        end
        StFetch: r_state <= StLatch;
        StLatch: begin
          r_ir    <= iram_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= StExec;
        end
        StExec: begin
          r_state <= StFetch;
          case (w_op)
            OpMova: r_regs[w_n] <= r_ac;
            OpInc:  r_regs[w_n] <= w_rn + DATA_W'(1);
            OpJnz:  if (!r_z) r_pc <= w_target;
            OpJmp:  r_pc <= w_target;
            OpLoad, OpStore: begin
              // Bus fields are captured once here and stay stable until granted.
              r_state      <= StMem;
              r_dram_req   <= 1'b1;
              r_dram_wren  <= (w_op == OpStore);
              r_dram_addr  <= w_rn[ADDR_W-1:0];
              r_dram_wdata <= r_ac;
            end
            OpEnd: begin
              r_state <= StHalt;
              r_busy  <= 1'b0;
              r_end   <= 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          if (dram_gnt) begin
            r_dram_req  <= 1'b0;
            r_dram_wren <= 1'b0;
            r_state     <= r_dram_wren ? StFetch : StMemWait;
          end
        end
        StMemWait: r_state <= StFetch;
        StHalt: ;
        default: r_state <= StIdle;
      endcase
      if (w_ac_we) begin
        r_ac <= w_ac_new;
        r_z  <= w_ac_zero;
      end
    end
  end

  assign iram_addr   = r_pc;
  assign pc_out      = r_pc;
  assign ac_out      = r_ac;
  assign z           = r_z;
  assign dram_req    = r_dram_req;
  assign dram_wren   = r_dram_wren;
  assign dram_addr   = r_dram_addr;
  assign dram_wdata  = r_dram_wdata;
  assign busy        = r_busy;
  assign end_process = r_end;

endmodule

// File: tb/tb_param_core.sv
// Directed bench for param_core: a 16-bit instance with IRAM/DRAM models and an 8-bit, 4-reg one.
module tb_param_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit instance
  logic        start16 = 1'b0;
  logic [15:0] core_id16 = 16'h0002;
  logic [15:0] iaddr16, irdata16, daddr16, dwdata16, drdata16, pc16, ac16;
  logic        req16, wren16, z16, busy16, end16;
  logic        gnt16 = 1'b0;
  logic [15:0] iram16 [256];
  logic [15:0] dram16 [256];
  int          wr_count16 = 0;
  logic [15:0] wr_addr16 = '0;
  logic [15:0] wr_data16 = '0;

  // 8-bit instance
  logic        start8 = 1'b0;
  logic [7:0]  core_id8 = 8'h05;
  logic [7:0]  iaddr8, irdata8, daddr8, dwdata8, pc8, ac8;
  logic [7:0]  drdata8 = 8'h00;
  logic        req8, wren8, z8, busy8, end8;
  logic        gnt8 = 1'b1;
  logic [7:0]  iram8 [256];

  int unsigned loop_pc [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 7, 5, 6, 7, 5, 6, 7, 8};

  param_core u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .core_id(core_id16),
    .iram_addr(iaddr16), .iram_rdata(irdata16),
    .dram_req(req16), .dram_gnt(gnt16), .dram_wren(wren16), .dram_addr(daddr16),
    .dram_wdata(dwdata16), .dram_rdata(drdata16),
    .pc_out(pc16), .ac_out(ac16), .z(z16), .busy(busy16), .end_process(end16)
  );

  param_core #(.DATA_W(8), .ADDR_W(8), .NREG(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .core_id(core_id8),
    .iram_addr(iaddr8), .iram_rdata(irdata8),
    .dram_req(req8), .dram_gnt(gnt8), .dram_wren(wren8), .dram_addr(daddr8),
    .dram_wdata(dwdata8), .dram_rdata(drdata8),
    .pc_out(pc8), .ac_out(ac8), .z(z8), .busy(busy8), .end_process(end8)
  );

  // Synchronous memories: data one cycle after address.
  always @(posedge clk) begin
    irdata16 <= iram16[iaddr16[7:0]];
    drdata16 <= dram16[daddr16[7:0]];
    irdata8  <= iram8[iaddr8];
  end

  // Write log for the 16-bit instance.
  always @(posedge clk) begin
    if (req16 && gnt16 && wren16) begin
      wr_count16 <= wr_count16 + 1;
      wr_addr16  <= daddr16;
      wr_data16  <= dwdata16;
    end
  end

  task automatic clear_iram();
    for (int i = 0; i < 256; i++) begin
      iram16[i] = 16'h0000;
      iram8[i]  = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gnt16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse start and count edges until end_process; -1 if it never arrives.
  task automatic run_prog(input bit sel8, output int cycles);
    @(negedge clk);
    if (sel8) start8 = 1'b1;
    else start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    start8  = 1'b0;
    cycles = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if ((sel8 ? end8 : end16) === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc16 !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc16); end
    checks++; if (ac16 !== 16'h0) begin errors++; $display("FAIL rst_ac: got %h want 0", ac16); end
    checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL rst_z: got %b want 1", z16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy16); end
    checks++; if (end16 !== 1'b0) begin errors++; $display("FAIL rst_end: got %b want 0", end16); end
    checks++; if (req16 !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req16); end
    checks++; if (iaddr16 !== 16'h0) begin errors++; $display("FAIL rst_iaddr: got %h want 0", iaddr16); end
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL rst_z8: got %b want 1", z8); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy16); end
    checks++; if (pc16 !== 16'h0) begin errors++; $display("FAIL idle_pc: got %h want 0", pc16); end
  endtask

  task automatic test_add();
    int cyc;
    clear_iram();
    iram16[0] = 16'h1005; iram16[1] = 16'h3001; iram16[2] = 16'h1003;
    iram16[3] = 16'h4001; iram16[4] = 16'hF000;
    do_reset();
    run_prog(1'b0, cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL add_cycles: got %0d want 15", cyc); end
    checks++; if (ac16 !== 16'd8) begin errors++; $display("FAIL add_ac: got %h want 0008", ac16); end
    checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL add_z: got %b want 0", z16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL add_busy: got %b want 0", busy16); end
    // start in HALT must not restart the core
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (end16 !== 1'b1) begin errors++; $display("FAIL halt_end: got %b want 1", end16); end
    checks++; if (pc16 !== 16'd5) begin errors++; $display("FAIL halt_pc: got %h want 0005", pc16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL halt_busy: got %b want 0", busy16); end
  endtask

  task automatic test_sub_mul();
    int cyc;
    clear_iram();
    iram16[0] = 16'h1001; iram16[1] = 16'h5000; iram16[2] = 16'hF000;
    do_reset();
    run_prog(1'b0, cyc);
    checks++; if (ac16 !== 16'd1) begin errors++; $display("FAIL sub0_ac: got %h want 0001", ac16); end
    checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL sub0_z: got %b want 0", z16); end
    iram16[2] = 16'h6000; iram16[3] = 16'hF000;
    do_reset();
    run_prog(1'b0, cyc);
    checks++; if (ac16 !== 16'd0) begin errors++; $display("FAIL mul0_ac: got %h want 0000", ac16); end
    checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL mul0_z: got %b want 1", z16); end
    clear_iram();
    iram16[0] = 16'h7002; iram16[1] = 16'h1000; iram16[2] = 16'h5002; iram16[3] = 16'hF000;
    do_reset();
    run_prog(1'b0, cyc);
    checks++; if (ac16 !== 16'hFFFF) begin errors++; $display("FAIL subwrap_ac: got %h want ffff", ac16); end
    checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL subwrap_z: got %b want 0", z16); end
  endtask

  task automatic test_store_wait();
    int base;
    int req_cyc;
    bit stable;
    clear_iram();
    iram16[0] = 16'h1020; iram16[1] = 16'h3004; iram16[2] = 16'h1077;
    iram16[3] = 16'h9004; iram16[4] = 16'hF000;
    do_reset();
    base = wr_count16;
    @(negedge clk); start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    req_cyc = 0;
    stable = 1'b1;
    for (int k = 0; k < 200 && end16 !== 1'b1; k++) begin
      @(posedge clk);
      #1;
      gnt16 = 1'b0;
      if (req16 === 1'b1) begin
        req_cyc++;
        if (daddr16 !== 16'h0020 || dwdata16 !== 16'h0077 || wren16 !== 1'b1) stable = 1'b0;
        if (req_cyc == 5) gnt16 = 1'b1;
      end
    end
    checks++; if (req_cyc != 5) begin errors++; $display("FAIL st_req_cycles: got %0d want 5", req_cyc); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL st_stable: got %b want 1", stable); end
    checks++;
    if (wr_count16 - base != 1) begin
      errors++; $display("FAIL st_writes: got %0d want 1", wr_count16 - base);
    end
    checks++; if (wr_addr16 !== 16'h0020) begin errors++; $display("FAIL st_addr: got %h want 0020", wr_addr16); end
    checks++; if (wr_data16 !== 16'h0077) begin errors++; $display("FAIL st_data: got %h want 0077", wr_data16); end
    checks++; if (end16 !== 1'b1) begin errors++; $display("FAIL st_end: got %b want 1", end16); end
  endtask

  task automatic test_load_ldid();
    int cyc;
    int base;
    clear_iram();
    dram16[16] = 16'hBEEF;
    iram16[0] = 16'h1010; iram16[1] = 16'h3003; iram16[2] = 16'h1000;
    iram16[3] = 16'h8003; iram16[4] = 16'hF000;
    do_reset();
    gnt16 = 1'b1;
    base = wr_count16;
    run_prog(1'b0, cyc);
    gnt16 = 1'b0;
    checks++; if (cyc != 17) begin errors++; $display("FAIL ld_cycles: got %0d want 17", cyc); end
    checks++; if (ac16 !== 16'hBEEF) begin errors++; $display("FAIL ld_ac: got %h want beef", ac16); end
    checks++; if (z16 !== 1'b0) begin errors++; $display("FAIL ld_z: got %b want 0", z16); end
    checks++;
    if (wr_count16 != base) begin errors++; $display("FAIL ld_nowrite: got %0d want %0d", wr_count16, base); end
    clear_iram();
    iram16[0] = 16'hC000; iram16[1] = 16'hF000;
    do_reset();
    run_prog(1'b0, cyc);
    checks++; if (cyc != 6) begin errors++; $display("FAIL ldid_cycles: got %0d want 6", cyc); end
    checks++; if (ac16 !== 16'h0002) begin errors++; $display("FAIL ldid_ac: got %h want 0002", ac16); end
  endtask

  task automatic test_loop();
    clear_iram();
    iram16[0] = 16'h1004; iram16[1] = 16'h3001; iram16[2] = 16'h1000;
    iram16[3] = 16'h5001; iram16[4] = 16'h3000; iram16[5] = 16'h7000;
    iram16[6] = 16'h2000; iram16[7] = 16'hA005; iram16[8] = 16'hF000;
    do_reset();
    @(negedge clk); start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin
        repeat (3) @(posedge clk);
        #1;
      end
      checks++;
      if (pc16 !== 16'(loop_pc[i])) begin
        errors++; $display("FAIL loop_pc[%0d]: got %h want %h", i, pc16, 16'(loop_pc[i]));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (end16 !== 1'b1) begin errors++; $display("FAIL loop_end: got %b want 1", end16); end
    checks++; if (ac16 !== 16'h0) begin errors++; $display("FAIL loop_ac: got %h want 0000", ac16); end
    checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL loop_z: got %b want 1", z16); end
  endtask

  task automatic test_reset_mid_mem();
    int base;
    bit saw_req;
    clear_iram();
    iram16[0] = 16'h1033; iram16[1] = 16'h7001; iram16[2] = 16'h9001; iram16[3] = 16'hF000;
    do_reset();
    base = wr_count16;
    @(negedge clk); start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    saw_req = 1'b0;
    for (int k = 0; k < 50 && !saw_req; k++) begin
      @(posedge clk);
      #1;
      if (req16 === 1'b1) saw_req = 1'b1;
    end
    checks++; if (saw_req !== 1'b1) begin errors++; $display("FAIL mr_saw_req: got %b want 1", saw_req); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (req16 !== 1'b0) begin errors++; $display("FAIL mr_req: got %b want 0", req16); end
    checks++; if (wren16 !== 1'b0) begin errors++; $display("FAIL mr_wren: got %b want 0", wren16); end
    checks++; if (daddr16 !== 16'h0) begin errors++; $display("FAIL mr_addr: got %h want 0", daddr16); end
    checks++; if (dwdata16 !== 16'h0) begin errors++; $display("FAIL mr_wdata: got %h want 0", dwdata16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy16); end
    checks++; if (ac16 !== 16'h0) begin errors++; $display("FAIL mr_ac: got %h want 0", ac16); end
    checks++; if (pc16 !== 16'h0) begin errors++; $display("FAIL mr_pc: got %h want 0", pc16); end
    checks++; if (z16 !== 1'b1) begin errors++; $display("FAIL mr_z: got %b want 1", z16); end
    checks++;
    if (wr_count16 != base) begin errors++; $display("FAIL mr_nowrite: got %0d want %0d", wr_count16, base); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_param8();
    int cyc;
    clear_iram();
    iram8[0] = 8'h15; iram8[1] = 8'h31; iram8[2] = 8'h13; iram8[3] = 8'h41; iram8[4] = 8'hF0;
    do_reset();
    run_prog(1'b1, cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL p8_cycles: got %0d want 15", cyc); end
    checks++; if (ac8 !== 8'd8) begin errors++; $display("FAIL p8_add_ac: got %h want 08", ac8); end
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL p8_add_z: got %b want 0", z8); end
    clear_iram();
    iram8[0] = 8'h72; iram8[1] = 8'h10; iram8[2] = 8'h52; iram8[3] = 8'hF0;
    do_reset();
    run_prog(1'b1, cyc);
    checks++; if (ac8 !== 8'hFF) begin errors++; $display("FAIL p8_wrap_ac: got %h want ff", ac8); end
    clear_iram();
    iram8[0] = 8'h11; iram8[1] = 8'h50; iram8[2] = 8'h60; iram8[3] = 8'hF0;
    do_reset();
    run_prog(1'b1, cyc);
    checks++; if (ac8 !== 8'h00) begin errors++; $display("FAIL p8_mul_ac: got %h want 00", ac8); end
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL p8_mul_z: got %b want 1", z8); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dram16[i] = 16'h0000;
    clear_iram();
    test_reset();
    test_add();
    test_sub_mul();
    test_store_wait();
    test_load_ldid();
    test_loop();
    test_reset_mid_mem();
    test_param8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
